lock_keypad_ctrl: RTL and testbench

//  Keypad-side front end of the digital lock. Accepts one key event per handshake:
//  hex digits plus SET / ENTER / CLEAR command keys. Assembles multi-digit PINs and

---
 rtl/lock_keypad_ctrl_pkg.sv | 26 ++
 rtl/lock_keypad_ctrl_timer.sv | 37 +++
 rtl/lock_keypad_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_lock_keypad_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_keypad_ctrl_pkg.sv
// Shared key codes, FSM state encodings and small decode helpers
// for the lock keypad front end.
package lock_keypad_ctrl_pkg;

    // Command key codes; 0x00-0x0F are hex digits, other codes are illegal.
    localparam logic [4:0] KEY_SET   = 5'h10;
    localparam logic [4:0] KEY_ENTER = 5'h11;
    localparam logic [4:0] KEY_CLR   = 5'h12;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SET_ENT  = 3'd1;
    localparam logic [2:0] ST_LOG_ENT  = 3'd2;
    localparam logic [2:0] ST_ISSUE    = 3'd3;
    localparam logic [2:0] ST_WAIT_RES = 3'd4;
    localparam logic [2:0] ST_LOCKOUT  = 3'd5;

    function automatic logic key_is_digit(input logic [4:0] code);
        return code[4] == 1'b0;
    endfunction

    // States in which the keypad handshake is open.
    function automatic logic st_takes_keys(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_SET_ENT) || (st == ST_LOG_ENT);
    endfunction

endpackage

// File: rtl/lock_keypad_ctrl_timer.sv
// Loadable down-counter with a zero flag; load wins over count enable.
// Ports: clk, rst (sync, active high), load_i/load_val_i, en_i, zero_o.
module lock_keypad_ctrl_timer #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_keypad_ctrl.sv
// Keypad front end of the digital lock: assembles PINs from key events,
// issues enrol/attempt strobes, reports the result and enforces lockout.
// Ports: clk, rst (sync, active high); key_valid/key_code/key_ready handshake;
//        lock, intrusion_alert from the lock; pin/set_pin, login_pin/login to
//        the lock; granted/denied/entry_err pulses; locked_out level.
module lock_keypad_ctrl
    import lock_keypad_ctrl_pkg::*;
#(
    parameter int PIN_W       = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCKOUT_CYC = 64,
    parameter int RESULT_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    output logic             key_ready,
    input  logic             lock,
    input  logic             intrusion_alert,
    output logic [PIN_W-1:0] pin,
    output logic             set_pin,
    output logic [PIN_W-1:0] login_pin,
    output logic             login,
    output logic             granted,
    output logic             denied,
    output logic             entry_err,
    output logic             locked_out
);

    localparam int NDIG  = PIN_W / 4;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int ET_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int LT_W  = $clog2(LOCKOUT_CYC + 1);
    localparam int RT_W  = $clog2(RESULT_WAIT + 1);

    // Entry timer fires on the TIMEOUT_CYC-th edge after the last key.
    localparam logic [ET_W-1:0] ET_LOAD = ET_W'(TIMEOUT_CYC - 1);
    // Lockout ends LOCKOUT_CYC edges after the last edge seeing the alert.
    localparam logic [LT_W-1:0] LT_LOAD = LT_W'(LOCKOUT_CYC - 1);
    // Result is sampled one edge after the counter drains.
    localparam logic [RT_W-1:0] RT_LOAD = RT_W'(RESULT_WAIT);

    logic [2:0]       state_q, state_d;
    logic [PIN_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_set_q, is_set_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [PIN_W-1:0] login_pin_q, login_pin_d;
    logic             set_pin_q, set_pin_d;
    logic             login_q, login_d;
    logic             granted_q, granted_d;
    logic             denied_q, denied_d;
    logic             err_q, err_d;
    logic             key_ready_q;
    logic             locked_out_q;

    logic et_load, et_en, et_zero;
    logic lt_load, lt_en, lt_zero;
    logic rt_load, rt_en, rt_zero;
    logic accept;
    logic full;

    assign accept = key_valid && key_ready_q;
    assign full   = (cnt_q == CNT_W'(NDIG));

    lock_keypad_ctrl_timer #(.MAX(TIMEOUT_CYC)) u_entry_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (et_load),
        .load_val_i (ET_LOAD),
        .en_i       (et_en),
        .zero_o     (et_zero)
    );

    lock_keypad_ctrl_timer #(.MAX(LOCKOUT_CYC)) u_lock_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (lt_load),
        .load_val_i (LT_LOAD),
        .en_i       (lt_en),
        .zero_o     (lt_zero)
    );

    lock_keypad_ctrl_timer #(.MAX(RESULT_WAIT)) u_res_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rt_load),
        .load_val_i (RT_LOAD),
        .en_i       (rt_en),
        .zero_o     (rt_zero)
    );

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        is_set_d    = is_set_q;
        pin_d       = pin_q;
        login_pin_d = login_pin_q;
        set_pin_d   = 1'b0;
        login_d     = 1'b0;
        granted_d   = 1'b0;
        denied_d    = 1'b0;
        err_d       = 1'b0;
        et_load     = 1'b0;
        et_en       = 1'b0;
        lt_load     = 1'b0;
        lt_en       = 1'b0;
        rt_load     = 1'b0;
        rt_en       = 1'b0;

        if (intrusion_alert) begin
            // Alert overrides everything and discards any partial entry.
            state_d = ST_LOCKOUT;
            sreg_d  = '0;
            cnt_d   = '0;
            lt_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (key_is_digit(key_code)) begin
                            state_d = ST_LOG_ENT;
                            sreg_d  = PIN_W'(key_code[3:0]);
                            cnt_d   = CNT_W'(1);
                            et_load = 1'b1;
                        end else if (key_code == KEY_SET) begin
                            state_d = ST_SET_ENT;
                            sreg_d  = '0;
                            cnt_d   = '0;
                            et_load = 1'b1;
                        end else if ((key_code != KEY_ENTER) &&
                                     (key_code != KEY_CLR)) begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_SET_ENT, ST_LOG_ENT: begin
                    et_en = 1'b1;
                    if (et_zero) begin
                        // Timeout outranks a key arriving on the same edge.
                        state_d = ST_IDLE;
                        sreg_d  = '0;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else if (accept) begin
                        et_load = 1'b1;
                        if (key_is_digit(key_code)) begin
                            if (full) begin
                                err_d = 1'b1;
                            end else begin
                                sreg_d = PIN_W'({sreg_q, key_code[3:0]});
                                cnt_d  = cnt_q + CNT_W'(1);
                            end
                        end else if (key_code == KEY_SET) begin
                            state_d = ST_SET_ENT;
                            sreg_d  = '0;
                            cnt_d   = '0;
                        end else if (key_code == KEY_ENTER) begin
                            if (full) begin
                                state_d  = ST_ISSUE;
                                is_set_d = (state_q == ST_SET_ENT);
                            end else begin
                                state_d = ST_IDLE;
                                sreg_d  = '0;
                                cnt_d   = '0;
                                err_d   = 1'b1;
                            end
                        end else if (key_code == KEY_CLR) begin
                            state_d = ST_IDLE;
                            sreg_d  = '0;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    sreg_d = '0;
                    cnt_d  = '0;
                    if (is_set_q) begin
                        pin_d     = sreg_q;
                        set_pin_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        login_pin_d = sreg_q;
                        login_d     = 1'b1;
                        rt_load     = 1'b1;
                        state_d     = ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    rt_en = 1'b1;
                    if (rt_zero) begin
                        granted_d = lock;
                        denied_d  = ~lock;
                        state_d   = ST_IDLE;
                    end
                end
                ST_LOCKOUT: begin
                    lt_en = 1'b1;
                    if (lt_zero) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            is_set_q     <= 1'b0;
            pin_q        <= '0;
            login_pin_q  <= '0;
            set_pin_q    <= 1'b0;
            login_q      <= 1'b0;
            granted_q    <= 1'b0;
            denied_q     <= 1'b0;
            err_q        <= 1'b0;
            key_ready_q  <= 1'b1;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            is_set_q     <= is_set_d;
            pin_q        <= pin_d;
            login_pin_q  <= login_pin_d;
            set_pin_q    <= set_pin_d;
            login_q      <= login_d;
            granted_q    <= granted_d;
            denied_q     <= denied_d;
            err_q        <= err_d;
            key_ready_q  <= st_takes_keys(state_d);
            locked_out_q <= (state_d == ST_LOCKOUT);
        end
    end

    assign key_ready  = key_ready_q;
    assign pin        = pin_q;
    assign set_pin    = set_pin_q;
    assign login_pin  = login_pin_q;
    assign login      = login_q;
    assign granted    = granted_q;
    assign denied     = denied_q;
    assign entry_err  = err_q;
    assign locked_out = locked_out_q;

endmodule

// File: tb/tb_lock_keypad_ctrl.sv
// Bench for lock_keypad_ctrl: directed scenarios plus random key traffic,
// checked every cycle against a behavioural model of the keypad rules.
module tb_lock_keypad_ctrl;

    localparam int PIN_W = 8;
    localparam int NDIG  = PIN_W / 4;
    localparam int TCYC  = 10;
    localparam int LCYC  = 16;
    localparam int RW    = 2;
    localparam logic [7:0] SECRET = 8'h3C;

    localparam logic [4:0] K_SET   = 5'h10;
    localparam logic [4:0] K_ENTER = 5'h11;
    localparam logic [4:0] K_CLR   = 5'h12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kv = 1'b0;
    logic [4:0] kc = 5'h0;
    logic alert = 1'b0;
    logic lock;
    logic key_ready, set_pin, login, granted, denied, entry_err, locked_out;
    logic [PIN_W-1:0] pin, login_pin;

    logic kv4 = 1'b0;
    logic [4:0] kc4 = 5'h0;
    logic key_ready4, set_pin4, login4, granted4, denied4, err4, lo4;
    logic [3:0] pin4, login_pin4;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    // Lock model: open exactly when the last attempt matches the secret.
    assign lock = (login_pin == SECRET);

    lock_keypad_ctrl #(
        .PIN_W(PIN_W), .TIMEOUT_CYC(TCYC),
        .LOCKOUT_CYC(LCYC), .RESULT_WAIT(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .key_valid(kv), .key_code(kc), .key_ready(key_ready),
        .lock(lock), .intrusion_alert(alert),
        .pin(pin), .set_pin(set_pin),
        .login_pin(login_pin), .login(login),
        .granted(granted), .denied(denied),
        .entry_err(entry_err), .locked_out(locked_out)
    );

    lock_keypad_ctrl #(
        .PIN_W(4), .TIMEOUT_CYC(TCYC),
        .LOCKOUT_CYC(LCYC), .RESULT_WAIT(RW)
    ) dut4 (
        .clk(clk), .rst(rst),
        .key_valid(kv4), .key_code(kc4), .key_ready(key_ready4),
        .lock(1'b0), .intrusion_alert(1'b0),
        .pin(pin4), .set_pin(set_pin4),
        .login_pin(login_pin4), .login(login4),
        .granted(granted4), .denied(denied4),
        .entry_err(err4), .locked_out(lo4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_ENROL, M_LOGIN, M_ISSUE, M_AWAIT, M_LOCK} mode_t;
    mode_t mode = M_IDLE;
    int unsigned dq[$];
    longint n = 0;
    longint last_key = 0;
    longint due = 0;
    longint rel = 0;
    bit is_set = 1'b0;
    logic e_ready = 1'b1, e_set = 1'b0, e_login = 1'b0, e_gr = 1'b0;
    logic e_dn = 1'b0, e_err = 1'b0, e_lo = 1'b0;
    logic [PIN_W-1:0] e_pin = '0, e_lpin = '0;

    task automatic model_step();
        bit acc;
        bit dig;
        logic [PIN_W-1:0] v;
        n++;
        acc = kv && e_ready;
        dig = (kc < 5'h10);
        e_set = 0; e_login = 0; e_gr = 0; e_dn = 0; e_err = 0;
        if (rst) begin
            mode = M_IDLE; dq.delete(); e_pin = '0; e_lpin = '0;
        end else if (alert) begin
            mode = M_LOCK; dq.delete(); rel = n + LCYC;
        end else begin
            case (mode)
                M_IDLE: if (acc) begin
                    if (dig) begin
                        mode = M_LOGIN; dq.delete(); dq.push_back(kc); last_key = n;
                    end else if (kc == K_SET) begin
                        mode = M_ENROL; dq.delete(); last_key = n;
                    end else if (kc != K_ENTER && kc != K_CLR) begin
                        e_err = 1;
                    end
                end
                M_ENROL, M_LOGIN: begin
                    if (n - last_key == TCYC) begin
                        e_err = 1; mode = M_IDLE; dq.delete();
                    end else if (acc) begin
                        last_key = n;
                        if (dig) begin
                            if (dq.size() == NDIG) e_err = 1;
                            else dq.push_back(kc);
                        end else if (kc == K_SET) begin
                            mode = M_ENROL; dq.delete();
                        end else if (kc == K_ENTER) begin
                            if (dq.size() == NDIG) begin
                                is_set = (mode == M_ENROL); mode = M_ISSUE;
                            end else begin
                                e_err = 1; mode = M_IDLE; dq.delete();
                            end
                        end else if (kc == K_CLR) begin
                            mode = M_IDLE; dq.delete();
                        end else begin
                            e_err = 1;
                        end
                    end
                end
                M_ISSUE: begin
                    v = '0;
                    foreach (dq[i]) v = (v << 4) | PIN_W'(dq[i]);
                    dq.delete();
                    if (is_set) begin
                        e_pin = v; e_set = 1; mode = M_IDLE;
                    end else begin
                        e_lpin = v; e_login = 1; mode = M_AWAIT; due = n + RW + 1;
                    end
                end
                M_AWAIT: if (n == due) begin
                    e_gr = lock; e_dn = !lock; mode = M_IDLE;
                end
                M_LOCK: if (n == rel) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
        e_ready = (mode == M_IDLE) || (mode == M_ENROL) || (mode == M_LOGIN);
        e_lo = (mode == M_LOCK);
        started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("key_ready", key_ready, e_ready);
            chk("pin", pin, e_pin);
            chk("set_pin", set_pin, e_set);
            chk("login_pin", login_pin, e_lpin);
            chk("login", login, e_login);
            chk("granted", granted, e_gr);
            chk("denied", denied, e_dn);
            chk("entry_err", entry_err, e_err);
            chk("locked_out", locked_out, e_lo);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [4:0] k);
        @(negedge clk); kv = 1'b1; kc = k;
        @(negedge clk); kv = 1'b0;
    endtask

    task automatic press4(input logic [4:0] k);
        @(negedge clk); kv4 = 1'b1; kc4 = k;
        @(negedge clk); kv4 = 1'b0;
    endtask

    function automatic logic [4:0] rand_key();
        int r = $urandom_range(0, 99);
        if (r < 20) return 5'h03;
        if (r < 35) return 5'h0C;
        if (r < 55) return 5'($urandom_range(0, 15));
        if (r < 67) return K_SET;
        if (r < 82) return K_ENTER;
        if (r < 90) return K_CLR;
        return 5'($urandom_range(19, 31));
    endfunction

    initial begin
        int gap = 0;
        int abur = 0;
        int rbur = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_pin", pin, 8'h00);
        rst = 1'b0;

        // 4-bit PIN enrol
        press4(K_SET); press4(5'h0A); press4(K_ENTER);
        chk("p4_no_strobe_yet", set_pin4, 1'b0);
        @(negedge clk);
        chk("p4_set_pin", set_pin4, 1'b1);
        chk("p4_pin", pin4, 4'hA);
        chk("p4_login", login4, 1'b0);
        @(negedge clk);
        chk("p4_set_pin_fall", set_pin4, 1'b0);

        // matching attempt
        press(5'h03); press(5'h0C); press(K_ENTER);
        @(negedge clk);
        chk("grant_login", login, 1'b1);
        chk("grant_login_pin", login_pin, 8'h3C);
        repeat (RW) @(negedge clk);
        chk("grant_early", granted, 1'b0);
        @(negedge clk);
        chk("granted", granted, 1'b1);

        // wrong attempt
        press(5'h03); press(5'h0D); press(K_ENTER);
        repeat (RW + 2) @(negedge clk);
        chk("denied", denied, 1'b1);
        chk("denied_login_pin", login_pin, 8'h3D);

        // short enrol, then overlong enrol
        press(K_SET); press(5'h01); press(K_ENTER);
        chk("short_err", entry_err, 1'b1);
        @(negedge clk);
        chk("short_no_set", set_pin, 1'b0);
        press(K_SET); press(5'h01); press(5'h02); press(5'h03);
        chk("extra_digit_err", entry_err, 1'b1);
        press(K_ENTER);
        @(negedge clk);
        chk("enrol_set_pin", set_pin, 1'b1);
        chk("enrol_pin", pin, 8'h12);

        // timeout
        press(5'h05);
        repeat (TCYC - 1) @(negedge clk);
        chk("timeout_early", entry_err, 1'b0);
        @(negedge clk);
        chk("timeout_err", entry_err, 1'b1);
        press(K_ENTER);
        repeat (2) @(negedge clk);
        chk("after_to_no_login", login, 1'b0);
        press(5'h05); press(5'h05); press(K_ENTER);
        @(negedge clk);
        chk("after_to_login_pin", login_pin, 8'h55);

        // intrusion during login entry
        repeat (RW + 2) @(negedge clk);
        press(5'h03);
        alert = 1'b1;
        @(negedge clk);
        chk("alert_lo", locked_out, 1'b1);
        chk("alert_ready", key_ready, 1'b0);
        repeat (2) @(negedge clk);
        alert = 1'b0; kv = 1'b1; kc = 5'h07;
        for (int j = 1; j < LCYC; j++) begin
            @(negedge clk);
            chk("lockout_ready", key_ready, 1'b0);
        end
        @(negedge clk);
        kv = 1'b0;
        chk("lockout_release", locked_out, 1'b0);
        chk("lockout_ready_back", key_ready, 1'b1);

        // reset while waiting for the result
        press(5'h03); press(5'h0C); press(K_ENTER);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_login_pin", login_pin, 8'h00);
        chk("rst_mid_ready", key_ready, 1'b1);
        for (int j = 0; j < RW + 2; j++) begin
            @(negedge clk);
            chk("rst_mid_no_result", {granted, denied}, 2'b00);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (gap > 0) begin
                gap--;
                kv = 1'b0;
            end else begin
                if ($urandom_range(0, 40) == 0) gap = $urandom_range(8, 14);
                kv = ($urandom_range(0, 99) < 45);
                kc = rand_key();
            end
            if (abur > 0) begin
                abur--; alert = 1'b1;
            end else begin
                alert = 1'b0;
                if ($urandom_range(0, 399) == 0) abur = $urandom_range(1, 4);
            end
            if (rbur > 0) begin
                rbur--; rst = 1'b1;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 699) == 0) rbur = $urandom_range(1, 2);
            end
        end
        @(negedge clk);
        kv = 1'b0; alert = 1'b0; rst = 1'b0;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
